// File: rtl/latch_q_monitor.sv
// latch_q_monitor: synchronises and debounces a latch q output, tracks the
// clean level, and queues every accepted level change as a timestamped event
// in a first-word fall-through FIFO with a valid/ready handshake.
module latch_q_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int TS_W          = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     q_in,
  output logic                     level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic                     evt_level,
  output logic [TS_W-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

  // A sample is usable only when it is a clean 0 or 1; X/Z never counts.
  function automatic logic is_known(input logic b);
    return (b === 1'b0) || (b === 1'b1);
  endfunction

  logic              s1;
  logic              s2;
  logic [CNT_W-1:0]  cnt;
  logic [TS_W-1:0]   ts;
  logic              mismatch;
  logic              evt_push;

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              mem_level [DEPTH];
  logic [TS_W-1:0]   mem_ts    [DEPTH];
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              ovf_set;

  // Stage 1/2: two-flop synchroniser, X/Z passed through unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
    end
  end

  // Stage 3: debounce decision on the synchronised sample
  always_comb begin
    mismatch = is_known(s2) && (s2 !== level);
    evt_push = mismatch && (cnt == CNT_LAST);
  end

  // Stage 3: debounce counter and accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (mismatch) begin
      if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Free-running timestamp; an event takes the pre-increment value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_ONE;
    end
  end

  // Stage 4: FIFO control; a full FIFO still accepts a push if the head leaves
  always_comb begin
    count     = wr_ptr - rd_ptr;
    evt_valid = (count != '0);
    full      = (count == FULL_CNT);
    pop       = evt_valid && evt_ready;
    wr_en     = evt_push && (!full || pop);
    ovf_set   = evt_push && full && !pop;
    evt_level = mem_level[rd_ptr[AW-1:0]];
    evt_ts    = mem_ts[rd_ptr[AW-1:0]];
  end

  // Stage 4: FIFO pointers; storage is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_level[i] <= 1'b0;
        mem_ts[i]    <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_level[wr_ptr[AW-1:0]] <= s2;
        mem_ts[wr_ptr[AW-1:0]]    <= ts;
        wr_ptr                    <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_latch_q_monitor.sv
// Bench for latch_q_monitor: directed scenarios followed by randomized
// q_in / evt_ready / clr_overflow / reset traffic, scored against a
// window-based reference model with a separate output monitor.
module tb_latch_q_monitor;

  localparam int SC = 4;
  localparam int TW = 6;
  localparam int DP = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   q_in;
  logic                   level;
  logic                   evt_valid;
  logic                   evt_ready;
  logic                   evt_level;
  logic [TW-1:0]          evt_ts;
  logic [$clog2(DP):0]    count;
  logic                   overflow;
  logic                   clr_overflow;

  latch_q_monitor #(
    .STABLE_CYCLES(SC),
    .TS_W         (TW),
    .DEPTH        (DP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_in        (q_in),
    .level       (level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_level   (evt_level),
    .evt_ts      (evt_ts),
    .count       (count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Reference model state (written only by the model process)
  logic          m_s1, m_s2, m_level, m_ovf;
  logic [TW-1:0] m_ts;
  int            occ = 0;
  logic          win[$];
  int            rst_cnt = 0;
  logic          m_ev, m_pop, m_push;
  logic          sb_lvl [256];
  logic [TW-1:0] sb_ts  [256];
  logic [7:0]    sb_wr = 8'd0;

  // Monitor state (written only by the monitor process)
  logic [7:0]    sb_rd = 8'd0;
  int            rst_seen = 0;
  int            tests = 0;
  int            fails = 0;

  // Model: a level is accepted once the last SC synchronised samples all
  // equal the opposite known value; the FIFO is modelled as an occupancy
  // count plus the ordered list of accepted events.
  initial begin
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_ovf = 1'b0; m_ts = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_ovf = 1'b0; m_ts = '0;
        occ = 0;
        win.delete();
        rst_cnt++;
      end else begin
        m_pop = (occ > 0) && evt_ready;
        win.push_back(m_s2);
        if (win.size() > SC) void'(win.pop_front());
        m_ev = (win.size() == SC);
        foreach (win[i]) if (win[i] !== ~m_level) m_ev = 1'b0;
        m_push = m_ev && ((occ < DP) || m_pop);
        if (m_push) begin
          sb_lvl[sb_wr] = ~m_level;
          sb_ts[sb_wr]  = m_ts;
          sb_wr++;
        end
        if (m_ev && !m_push) m_ovf = 1'b1;
        else if (clr_overflow) m_ovf = 1'b0;
        occ = occ + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
        if (m_ev) m_level = ~m_level;
        m_ts = m_ts + 1'b1;
        m_s2 = m_s1;
        m_s1 = q_in;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge, pops the scoreboard
  // whenever the DUT completes a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_cnt != rst_seen) begin
        rst_seen = rst_cnt;
        sb_rd = sb_wr;
        chk("head_level_after_reset", int'(evt_level), 0);
        chk("head_ts_after_reset", int'(evt_ts), 0);
      end
      chk("level", int'(level), int'(m_level));
      chk("count", int'(count), occ);
      chk("evt_valid", int'(evt_valid), (occ != 0) ? 1 : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (evt_valid && evt_ready) begin
        if (sb_rd == sb_wr) begin
          chk("unexpected_event", 1, 0);
        end else begin
          chk("evt_level", int'(evt_level), int'(sb_lvl[sb_rd]));
          chk("evt_ts", int'(evt_ts), int'(sb_ts[sb_rd]));
          sb_rd++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int run;

  initial begin
    rst_n = 1'b0; q_in = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    // Idle, then a single rise and a pop
    cyc(20);
    q_in = 1'b1;
    cyc(10);
    evt_ready = 1'b1;
    cyc(2);
    evt_ready = 1'b0;

    // Fall, short glitch, then a pulse exactly SC cycles long
    q_in = 1'b0;
    cyc(10);
    q_in = 1'b1; cyc(3);
    q_in = 1'b0; cyc(10);
    q_in = 1'b1; cyc(SC);
    q_in = 1'b0; cyc(12);
    evt_ready = 1'b1;
    cyc(4);
    evt_ready = 1'b0;

    // Overflow: five toggles with the consumer stalled, drain, then clear
    for (int i = 0; i < 5; i++) begin
      q_in = ~q_in;
      cyc(6);
    end
    cyc(4);
    evt_ready = 1'b1;
    cyc(6);
    evt_ready = 1'b0;
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;

    // X on the input right after reset, then a clean 1
    rst_n = 1'b0; q_in = 1'bx;
    cyc(1);
    rst_n = 1'b1;
    cyc(10);
    q_in = 1'b1;
    cyc(10);
    evt_ready = 1'b1;
    cyc(2);
    evt_ready = 1'b0;

    // Reset mid-operation: FIFO full, overflow set, debounce mid-count
    for (int i = 0; i < 5; i++) begin
      q_in = ~q_in;
      cyc(6);
    end
    q_in = ~q_in;
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(12);
    evt_ready = 1'b1;
    cyc(3);

    // Randomized traffic with runs, X bursts, stalls, clears and resets
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        if ($urandom_range(0, 9) == 0) q_in = 1'bx;
        else q_in = 1'($urandom_range(0, 1));
        run = int'($urandom_range(1, 9));
      end
      run--;
      if ((i / 500) % 2 == 0) evt_ready = ($urandom_range(0, 3) == 0);
      else evt_ready = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 31) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(1);
    end

    // Drain
    rst_n = 1'b1; clr_overflow = 1'b0; evt_ready = 1'b1; q_in = 1'b0;
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
